stream_upsizer: RTL and testbench
=================================

Name: stream_upsizer

Overview:
- Width-packing stream stage: collects SCALE consecutive narrow beats into one wide word.
- Sits directly upstream of stream_downsizer, or anywhere a narrow producer must feed a wide consumer.
- Lane order matches stream_downsizer: the first accepted beat goes to lane 0 (LSBs). A round trip through both blocks therefore restores the original beat order.
- Supports early termination with s_last_i. A partial wide word is emitted together with a lane count.

Parameters:
- DW_IN, 8: width of one input beat, in bits.
- SCALE, 4: input beats per output word, >= 2. Output width is DW_IN*SCALE.
- TIMEOUT, 16: idle-flush threshold in cycles, >= 1. Used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data_i  in  DW_IN  input beat.
- s_valid_i  in  1  input beat valid.
- s_last_i  in  1  marks the final beat of a packet; qualified by s_valid_i.
- s_ready_o  out  1  input beat accepted when s_valid_i & s_ready_o.
- m_data_o  out  DW_IN*SCALE  packed word; lane k is bits [k*DW_IN +: DW_IN].
- m_valid_o  out  1  output word valid.
- m_last_o  out  1  word closed by s_last_i.
- m_cnt_o  out  $clog2(SCALE+1)  number of valid lanes, 1..SCALE.
- m_ready_i  in  1  output word consumed when m_valid_o & m_ready_i.

Behaviour:
- Definitions:
  - wr = s_valid_i & s_ready_o.
  - rd = m_valid_o & m_ready_i.
  - Internal state: assembly register asm[DW_IN*SCALE], lane index idx (0..SCALE-1), one-deep output register holding data/valid/last/cnt.
- s_ready_o = !rst_r & (!m_valid_o | m_ready_i).
  - rst_r is a flop set by rst and cleared on the next cycle.
  - So s_ready_o is 0 during reset and for the first cycle after it.
  - The combinational path m_ready_i -> s_ready_o is intended.
- On wr:
  - s_data_i is written to lane idx of the word being built.
  - The word closes when idx==SCALE-1 or s_last_i==1.
- On wr without close: idx increments.
- On wr with close:
  - The completed word, including the current beat, moves to the output register on the same edge.
  - Lanes above idx are zero.
  - Output cnt = idx+1; output last = s_last_i.
  - asm clears and idx returns to 0.
- Latency: the closing beat accepted in cycle N gives m_valid_o=1 in cycle N+1. Sustained throughput is one input beat per cycle when m_ready_i stays high.
- Output register:
  - m_valid_o is set on close.
  - It clears on rd when no close happens in the same cycle.
  - Close and rd in the same cycle: the new word replaces the old one and m_valid_o stays 1.
- While m_valid_o & !m_ready_i, m_data_o, m_last_o and m_cnt_o are held stable.
- s_last_i together with idx==SCALE-1 gives a full word with m_last_o=1 and m_cnt_o=SCALE.
- s_last_i at idx==0 gives a one-lane word with m_cnt_o=1.
- Reset values: m_valid_o=0, m_last_o=0, m_cnt_o=0, m_data_o=0, idx=0, asm=0.
- Reset mid-word discards the partial word and any pending output word. Nothing is emitted for them.

Optional Feature:
- Macro: STREAM_UPSIZER_TIMEOUT_EN.
- When defined, an idle counter runs while idx>0 and no wr occurs. It clears on every wr and when idx==0.
- When the counter reaches TIMEOUT and the output slot is free (!m_valid_o | m_ready_i), the partial word is flushed:
  - m_cnt_o = idx, m_last_o = 0, unused lanes zero, idx returns to 0.
- If the slot is not free, the flush waits. s_ready_o is unchanged.
- A wr in the same cycle as the threshold has priority: the beat is appended and the counter clears.
- When not defined, there is no counter and TIMEOUT is ignored. A partial word waits until s_last_i or a full word.

Test Plan (DW_IN=8, SCALE=4):
1. Continuous stream, m_ready_i=1: beats 0x11,0x22,0x33,0x44,0x55… -> m_data_o=0x44332211, m_cnt_o=4, m_last_o=0, valid one cycle after 0x44. Next word starts with 0x55 with no bubble.
2. Packet 0xAA,0xBB with s_last_i on 0xBB -> m_data_o=0x0000BBAA, m_cnt_o=2, m_last_o=1; next packet starts at lane 0.
3. Backpressure: m_ready_i=0 with a word pending -> s_ready_o=0; data stays stable for 5 cycles. Releasing m_ready_i gives the word exactly once, then accepting resumes.
4. s_last_i on the 4th beat -> m_cnt_o=4, m_last_o=1. s_last_i on the 1st beat -> m_data_o=0x000000CC, m_cnt_o=1.
5. rst asserted after 2 beats -> no output. s_ready_o=0 during reset and for one cycle after. The next 4 beats form a clean word at lane 0.
6. With STREAM_UPSIZER_TIMEOUT_EN and TIMEOUT=16: 3 beats then idle -> flush after 16 idle cycles with m_cnt_o=3, m_last_o=0. Without the macro, no output appears after 100 idle cycles.

Source files
------------

// File: rtl/stream_upsizer.sv
// Purpose : packs SCALE consecutive narrow beats into one wide word, lane 0 first; s_last_i closes a partial word.
// Latency : the closing beat accepted on edge N is presented on m_data_o after that edge (m_valid_o=1 in cycle N+1).
// Backpr. : one-deep output slot; s_ready_o = !m_valid_o | m_ready_i (combinational path), low during and one cycle after rst.
//
// Parameters
//   DW_IN   : width of one input beat in bits
//   SCALE   : input beats per output word (>= 2); output width DW_IN*SCALE
//   TIMEOUT : idle-flush threshold in cycles (>= 1), only used with STREAM_UPSIZER_TIMEOUT_EN
//
// Ports
//   clk, rst                         : clock, synchronous active-high reset
//   s_data_i/s_valid_i/s_last_i      : narrow input beat, valid, end-of-packet marker
//   s_ready_o                        : input beat accepted when s_valid_i & s_ready_o
//   m_data_o                         : packed word, lane k = bits [k*DW_IN +: DW_IN]
//   m_valid_o/m_last_o/m_cnt_o       : word valid, closed by s_last_i, number of valid lanes (1..SCALE)
//   m_ready_i                        : word consumed when m_valid_o & m_ready_i
//
// Optional feature (macro STREAM_UPSIZER_TIMEOUT_EN):
//   a partial word that sees TIMEOUT consecutive cycles without an accepted beat is
//   flushed with m_last_o=0 and m_cnt_o = number of lanes collected so far.

module stream_upsizer #(
    parameter int DW_IN   = 8,
    parameter int SCALE   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DW_IN-1:0]             s_data_i,
    input  logic                         s_valid_i,
    input  logic                         s_last_i,
    output logic                         s_ready_o,
    output logic [DW_IN*SCALE-1:0]       m_data_o,
    output logic                         m_valid_o,
    output logic                         m_last_o,
    output logic [$clog2(SCALE+1)-1:0]   m_cnt_o,
    input  logic                         m_ready_i
);

    localparam int DW_OUT = DW_IN * SCALE;
    localparam int IDX_W  = $clog2(SCALE);
    localparam int CNT_W  = $clog2(SCALE + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SCALE - 1);

    // Elaboration-time guard on the parameter ranges this block is built for.
    if (SCALE < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("stream_upsizer: SCALE must be >= 2 and TIMEOUT must be >= 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                rst_r;      // high during reset and for the cycle after it
    logic [DW_OUT-1:0]   asm_q;      // word under construction
    logic [IDX_W-1:0]    idx_q;      // lane the next accepted beat lands in

    // ------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------
    logic                slot_free;  // output register can take a new word this cycle
    logic                wr;
    logic                rd;
    logic                close;      // accepted beat finishes the current word
    logic                flush;      // idle timeout pushes out a partial word
    logic [DW_OUT-1:0]   asm_merged; // asm_q with the incoming beat placed in lane idx_q

    assign slot_free = !m_valid_o || m_ready_i;
    // The rst term keeps ready low in the very first reset cycle, before rst_r
    // has had an edge to pick reset up.
    assign s_ready_o = !rst && !rst_r && slot_free;
    assign wr        = s_valid_i && s_ready_o;
    assign rd        = m_valid_o && m_ready_i;
    assign close     = wr && ((idx_q == IDX_LAST) || s_last_i);

    // Lanes above idx_q are still zero here: asm_q is cleared whenever a word
    // leaves and lanes are filled strictly in ascending order.
    always_comb begin
        asm_merged = asm_q;
        for (int k = 0; k < SCALE; k++) begin
            if (idx_q == IDX_W'(k)) begin
                asm_merged[k*DW_IN +: DW_IN] = s_data_i;
            end
        end
    end

`ifdef STREAM_UPSIZER_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Idle-flush counter
    // ------------------------------------------------------------------
    localparam int               IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

    // idle_q counts completed idle cycles of a non-empty partial word. When it
    // holds TIMEOUT-1 and the current cycle is also idle, this is the
    // TIMEOUT-th idle cycle and the flush happens on the coming edge. It
    // saturates there so a flush blocked by a full output slot stays armed.
    logic [IDLE_W-1:0] idle_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else if (wr || (idx_q == '0)) begin
            idle_q <= '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_q <= idle_q + IDLE_W'(1);
        end
    end

    // An accepted beat in the threshold cycle wins: it is appended instead.
    assign flush = !wr && (idx_q != '0) && (idle_q == IDLE_MAX) && slot_free;
`else
    assign flush = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Assembly register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_r <= 1'b1;
            asm_q <= '0;
            idx_q <= '0;
        end else begin
            rst_r <= 1'b0;
            if (close) begin
                asm_q <= '0;
                idx_q <= '0;
            end else if (wr) begin
                asm_q <= asm_merged;
                idx_q <= idx_q + IDX_W'(1);
            end else if (flush) begin
                asm_q <= '0;
                idx_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // A close (or flush) only happens when the slot is free, so loading the
    // new word also covers the case where the old one is read on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data_o  <= '0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            m_cnt_o   <= '0;
        end else if (close) begin
            m_data_o  <= asm_merged;
            m_valid_o <= 1'b1;
            m_last_o  <= s_last_i;
            m_cnt_o   <= CNT_W'(idx_q) + CNT_W'(1);
        end else if (flush) begin
            m_data_o  <= asm_q;
            m_valid_o <= 1'b1;
            m_last_o  <= 1'b0;
            m_cnt_o   <= CNT_W'(idx_q);
        end else if (rd) begin
            m_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_upsizer.sv
// Bench for stream_upsizer (DW_IN=8, SCALE=4, TIMEOUT=16): directed scenarios followed by
// randomized traffic, all output words checked against a beat-queue reference model.
// Build with STREAM_UPSIZER_TIMEOUT_EN defined to exercise the idle flush.

module tb_stream_upsizer;

    localparam int DW = 8;
    localparam int SC = 4;
    localparam int TO = 16;
    localparam int OW = DW * SC;
    localparam int CW = $clog2(SC + 1);

    typedef struct packed {
        logic [OW-1:0] dat;
        logic [CW-1:0] cnt;
        logic          last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic [OW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic [CW-1:0] m_cnt;
    logic          m_ready;

    stream_upsizer #(
        .DW_IN   (DW),
        .SCALE   (SC),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_last_i  (s_last),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_last_o  (m_last),
        .m_cnt_o   (m_cnt),
        .m_ready_i (m_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: accepted beats gather in a queue; a word is due when
    // the queue holds SCALE beats or the beat carries last.
    // ------------------------------------------------------------------
    logic [DW-1:0] part[$];
    word_t         exp_q[$];
    word_t         w;
    logic          hold_vld = 1'b0;
    word_t         hold_word;

    function automatic word_t pack_word(input logic [DW-1:0] beats[$], input logic lst);
        word_t r;
        r.dat = '0;
        foreach (beats[i]) r.dat[i*DW +: DW] = beats[i];
        r.cnt  = CW'(beats.size());
        r.last = lst;
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            part.delete();
            exp_q.delete();
            hold_vld = 1'b0;
        end else begin
            // A stalled word must stay put until it is taken.
            if (hold_vld) begin
                chk("hold_vld", m_valid, 1'b1);
                chk("hold_word", {m_data, m_cnt, m_last}, hold_word);
            end
            hold_vld  = m_valid && !m_ready;
            hold_word = {m_data, m_cnt, m_last};

            if (m_valid && m_ready) begin
                if (exp_q.size() > 0) begin
                    w = exp_q.pop_front();
                    chk("word", {m_data, m_cnt, m_last}, w);
                end else begin
`ifdef STREAM_UPSIZER_TIMEOUT_EN
                    // With no word due, the only legal source is an idle flush.
                    if (part.size() > 0) begin
                        w = pack_word(part, 1'b0);
                        part.delete();
                        chk("flush_word", {m_data, m_cnt, m_last}, w);
                    end else begin
                        chk("unexpected_word", exp_q.size(), 1);
                    end
`else
                    chk("unexpected_word", exp_q.size(), 1);
`endif
                end
            end

            if (s_valid && s_ready) begin
                part.push_back(s_data);
                if (part.size() == SC || s_last) begin
                    exp_q.push_back(pack_word(part, s_last));
                    part.delete();
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called just after a rising edge)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_timeout", n, 0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [DW-1:0] b;
    int            t0;
    logic          seen;
    int            dly;
    logic [63:0]   w_got;
    logic          acc;
    int            vgap;
    int            rgap;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;

        // Reset state and ready release timing
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_cnt",   m_cnt,   0);
        chk("rst_m_last",  m_last,  0);
        chk("rst_m_data",  m_data,  0);
        chk("rst_s_ready", s_ready, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy_post1", s_ready, 0);
        step();
        @(negedge clk);
        chk("rst_rdy_post2", s_ready, 1);
        step();

        // 1: continuous stream
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        @(negedge clk);
        chk("t1_vld",  m_valid, 1);
        chk("t1_dat",  m_data,  32'h44332211);
        chk("t1_cnt",  m_cnt,   4);
        chk("t1_last", m_last,  0);
        step();
        t0 = cyc;
        b = 8'h55;
        for (int i = 0; i < 8; i++) begin
            send(b, 0);
            b = b + 8'h11;
        end
        chk("t1_no_bubble_cycles", cyc - t0, 8);

        // 2: short packet, then a fresh packet from lane 0
        send(8'hAA, 0); send(8'hBB, 1);
        @(negedge clk);
        chk("t2_dat",  m_data, 32'h0000BBAA);
        chk("t2_cnt",  m_cnt,  2);
        chk("t2_last", m_last, 1);
        step();
        send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
        @(negedge clk);
        chk("t2_next_dat", m_data, 32'hC4C3C2C1);
        chk("t2_next_cnt", m_cnt,  4);
        step();

        // 3: backpressure
        m_ready = 1'b0;
        send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 0); send(8'hD4, 0);
        s_valid = 1'b1; s_data = 8'hE1; s_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_rdy_stall", s_ready, 0);
            chk("t3_dat_stall", m_data, 32'hD4D3D2D1);
            step();
        end
        m_ready = 1'b1;
        @(negedge clk);
        chk("t3_vld_release", m_valid, 1);
        chk("t3_rdy_release", s_ready, 1);
        step();
        s_valid = 1'b0;
        @(negedge clk);
        chk("t3_once", m_valid, 0);
        step();
        send(8'hE2, 0); send(8'hE3, 0); send(8'hE4, 0);
        @(negedge clk);
        chk("t3_resume_dat", m_data, 32'hE4E3E2E1);
        step();

        // 4: last on the 4th beat and on the 1st beat
        send(8'hF1, 0); send(8'hF2, 0); send(8'hF3, 0); send(8'hF4, 1);
        @(negedge clk);
        chk("t4_full_cnt",  m_cnt,  4);
        chk("t4_full_last", m_last, 1);
        step();
        send(8'hCC, 1);
        @(negedge clk);
        chk("t4_one_dat",  m_data, 32'h000000CC);
        chk("t4_one_cnt",  m_cnt,  1);
        chk("t4_one_last", m_last, 1);
        step();

        // 5: reset mid-word
        send(8'h71, 0); send(8'h72, 0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_rst_vld", m_valid, 0);
            chk("t5_rst_rdy", s_ready, 0);
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rdy_post1", s_ready, 0);
        step();
        send(8'h81, 0); send(8'h82, 0); send(8'h83, 0); send(8'h84, 0);
        @(negedge clk);
        chk("t5_clean_dat", m_data, 32'h84838281);
        chk("t5_clean_cnt", m_cnt,  4);
        step();

        // 6: idle partial word
        send(8'h61, 0); send(8'h62, 0); send(8'h63, 0);
        seen = 1'b0; dly = 0; w_got = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (m_valid && !seen) begin
                seen  = 1'b1;
                dly   = i - 1;
                w_got = {m_data, m_cnt, m_last};
            end
            step();
        end
`ifdef STREAM_UPSIZER_TIMEOUT_EN
        chk("t6_flush_seen",  seen,  1);
        chk("t6_flush_delay", dly,   TO);
        chk("t6_flush_word",  w_got, {32'h00636261, 3'd3, 1'b0});
`else
        chk("t6_no_flush", seen, 0);
`endif

        // Randomized traffic; idle streaks are capped so no idle flush can fire.
        acc = 1'b0; vgap = 0; rgap = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!s_valid || acc) begin
                s_valid = ($urandom_range(0, 9) < 7) || (vgap >= 4);
                s_data  = DW'($urandom);
                s_last  = ($urandom_range(0, 7) == 0);
            end
            m_ready = ($urandom_range(0, 9) < 6) || (rgap >= 4);
            vgap = s_valid ? 0 : vgap + 1;
            rgap = m_ready ? 0 : rgap + 1;
            @(negedge clk);
            acc = s_valid && s_ready;
            step();
        end

        // Drain: close any partial word and let everything out
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        step();
        send(8'h5A, 1);
        repeat (4) step();
        chk("drain_words", exp_q.size(), 0);
        chk("drain_beats", part.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
